traffic_phase_sequencer: RTL

//   Phase sequencer for the intersection controller. Steps through four phases:
//   NS green, NS yellow, EW green, EW yellow. Each phase runs for a fixed number
//   of time-base ticks. Drives the 4-bit one-hot selector into the downstream
//   4-channel one-hot mux, which picks the per-phase light pattern.

---
 rtl/traffic_phase_sequencer.sv | 127 ++++++++++++
 1 files changed

// File: rtl/traffic_phase_sequencer.sv
// Four-phase intersection sequencer with pedestrian green shortening.
// Define ALL_RED_EN to insert an all-red clearance phase after every yellow.
module traffic_phase_sequencer #(
    parameter int CNT_WIDTH       = 8,
    parameter int GREEN_TICKS     = 20,
    parameter int YELLOW_TICKS    = 4,
    parameter int MIN_GREEN_TICKS = 5,
    parameter int ALLRED_TICKS    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 hold,
    input  logic                 ped_req,
    output logic [3:0]           selector,
    output logic [CNT_WIDTH-1:0] remaining,
    output logic                 phase_done,
    output logic                 ped_ack
);

`ifdef ALL_RED_EN
    localparam bit ALL_RED = 1'b1;
`else
    localparam bit ALL_RED = 1'b0;
`endif

    localparam logic [CNT_WIDTH-1:0] GREEN_LD  = CNT_WIDTH'(GREEN_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] YELLOW_LD = CNT_WIDTH'(YELLOW_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] MIN_LD    = CNT_WIDTH'(MIN_GREEN_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] ALLRED_LD = CNT_WIDTH'(ALLRED_TICKS - 1);

    // State encoding doubles as the mux selector, so selector is registered.
    typedef enum logic [3:0] {
        NS_G  = 4'b0001,
        NS_Y  = 4'b0010,
        EW_G  = 4'b0100,
        EW_Y  = 4'b1000,
        ALL_R = 4'b0000
    } phase_t;

    phase_t phase;
    logic   ped_pending;
    logic   ew_next;
    logic   adv;

    assign selector = phase;
    assign adv      = tick & ~hold;

    // A pending request cuts a long green down to the minimum remaining length.
    function automatic logic [CNT_WIDTH-1:0] green_count(
        input logic [CNT_WIDTH-1:0] rem,
        input logic                 pending
    );
        if (pending && (rem > MIN_LD))
            return MIN_LD;
        return rem - CNT_WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= NS_G;
            remaining   <= GREEN_LD;
            phase_done  <= 1'b0;
            ped_ack     <= 1'b0;
            ped_pending <= 1'b0;
            ew_next     <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            ped_ack    <= 1'b0;
            if (ped_req)
                ped_pending <= 1'b1;

            case (phase)
                NS_G, EW_G: begin
                    if (adv) begin
                        if (remaining == '0) begin
                            phase       <= (phase == NS_G) ? NS_Y : EW_Y;
                            remaining   <= YELLOW_LD;
                            phase_done  <= 1'b1;
                            ped_ack     <= ped_pending | ped_req;
                            ped_pending <= 1'b0;
                        end else begin
                            remaining <= green_count(remaining, ped_pending);
                        end
                    end
                end
                NS_Y, EW_Y: begin
                    if (adv) begin
                        if (remaining == '0) begin
                            phase_done <= 1'b1;
                            ew_next    <= (phase == NS_Y);
                            if (ALL_RED) begin
                                phase     <= ALL_R;
                                remaining <= ALLRED_LD;
                            end else begin
                                phase     <= (phase == NS_Y) ? EW_G : NS_G;
                                remaining <= GREEN_LD;
                            end
                        end else begin
                            remaining <= remaining - CNT_WIDTH'(1);
                        end
                    end
                end
                ALL_R: begin
                    if (!ALL_RED) begin
                        phase     <= NS_G;
                        remaining <= GREEN_LD;
                    end else if (adv) begin
                        if (remaining == '0) begin
                            phase      <= ew_next ? EW_G : NS_G;
                            remaining  <= GREEN_LD;
                            phase_done <= 1'b1;
                        end else begin
                            remaining <= remaining - CNT_WIDTH'(1);
                        end
                    end
                end
                // Any non-one-hot pattern falls back to the reset phase.
                default: begin
                    phase     <= NS_G;
                    remaining <= GREEN_LD;
                end
            endcase
        end
    end

endmodule
